// File: rtl/pass_tx.sv
// pass_tx: serial transmitter driving the (x, y) pair of an inhibit/pass gate
// (f = ~x & y). A WIDTH-bit word accepted over valid/ready is shifted out
// MSB-first on y, each bit held for DIV clocks, with x held low only while a
// bit is on the wire; x stays high (f = 0) at all other times.
//
// Optional build macro: PASS_TX_PARITY_EN -- when defined, one extra bit
// period of even parity (XOR of the data bits) follows the data bits.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous reset, active-high
//   data_in   word to transmit, captured on in_valid & in_ready
//   in_valid  data_in is valid
//   in_ready  block can accept a word this cycle
//   x         inhibit to the pass gate (1 = block, 0 = pass y)
//   y         serial data bit
//   busy      a frame is in progress (SEND or DONE)
//   done      one-cycle pulse after the last bit period
module pass_tx #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             x,
    output logic             y,
    output logic             busy,
    output logic             done
);

`ifdef PASS_TX_PARITY_EN
    localparam int unsigned NBITS = WIDTH + 1;
`else
    localparam int unsigned NBITS = WIDTH;
`endif
    localparam int unsigned SW = NBITS;
    localparam int unsigned BW = $clog2(NBITS + 1);
    localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   sh_q, sh_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [DW-1:0]   div_q, div_d;
    logic            x_q, x_d;
    logic            y_q, y_d;
    logic            in_ready_q, in_ready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [SW-1:0]   load_word;

    // The parity bit rides in the LSB of an extended shift register so it
    // simply follows the data bits out of the MSB.
`ifdef PASS_TX_PARITY_EN
    assign load_word = {data_in, ^data_in};
`else
    assign load_word = data_in;
`endif

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        bit_d   = bit_q;
        div_d   = div_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    sh_d    = load_word;
                    bit_d   = '0;
                    div_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    sh_d  = sh_q << 1;
                    bit_d = bit_q + BW'(1);
                    if (bit_q == BIT_LAST) begin
                        state_d = DONE;
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it;
        // y is forced low whenever x is high, so no spurious pass can occur.
        x_d        = (state_d != SEND);
        y_d        = (state_d == SEND) && sh_d[SW-1];
        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sh_q       <= '0;
            bit_q      <= '0;
            div_q      <= '0;
            x_q        <= 1'b1;
            y_q        <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            bit_q      <= bit_d;
            div_q      <= div_d;
            x_q        <= x_d;
            y_q        <= y_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign x        = x_q;
    assign y        = y_q;
    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_pass_tx.sv
// Directed bench for pass_tx: two instances (DIV=4 and DIV=1), a vector table
// of frames with hand-computed parity, plus reset, back-to-back and
// ignored-input sequences. Honours PASS_TX_PARITY_EN for frame length.
module tb_pass_tx;

`ifdef PASS_TX_PARITY_EN
    localparam int unsigned NB = 9;
`else
    localparam int unsigned NB = 8;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] d4, d1;
    logic       v4, v1;
    logic       r4, x4, y4, b4, dn4;
    logic       r1, x1, y1, b1, dn1;

    pass_tx #(.WIDTH(8), .DIV(4)) u_dut4 (
        .clk(clk), .rst(rst), .data_in(d4), .in_valid(v4),
        .in_ready(r4), .x(x4), .y(y4), .busy(b4), .done(dn4)
    );

    pass_tx #(.WIDTH(8), .DIV(1)) u_dut1 (
        .clk(clk), .rst(rst), .data_in(d1), .in_valid(v1),
        .in_ready(r1), .x(x1), .y(y1), .busy(b1), .done(dn1)
    );

    int total = 0;
    int bad   = 0;

    logic sel;  // 0: DIV=4 instance, 1: DIV=1 instance
    logic sx, sy, sr, sb, sd, sf;
    always_comb begin
        sx = sel ? x1  : x4;
        sy = sel ? y1  : y4;
        sr = sel ? r1  : r4;
        sb = sel ? b1  : b4;
        sd = sel ? dn1 : dn4;
        sf = ~sx & sy;
    end

    typedef struct {
        logic [7:0] data;
        logic       par;   // even parity, hand-computed
        logic       sel;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, ".x"},        32'(sx), 32'd1);
        chk({nm, ".y"},        32'(sy), 32'd0);
        chk({nm, ".in_ready"}, 32'(sr), 32'd1);
        chk({nm, ".busy"},     32'(sb), 32'd0);
        chk({nm, ".done"},     32'(sd), 32'd0);
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        @(negedge clk);
        while (sr !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({nm, ".wait_ready"}, 32'(sr), 32'd1);
    endtask

    // Called just after the accept edge; checks every bit-period cycle and
    // the DONE cycle.
    task automatic check_frame(input logic [7:0] data, input logic par,
                               input int unsigned div, input string nm);
        logic eb;
        for (int unsigned b = 0; b < NB; b++) begin
            eb = (b < 8) ? data[7-b] : par;
            for (int unsigned c = 0; c < div; c++) begin
                @(negedge clk);
                chk($sformatf("%s.b%0d.x", nm, b),    32'(sx), 32'd0);
                chk($sformatf("%s.b%0d.y", nm, b),    32'(sy), 32'(eb));
                chk($sformatf("%s.b%0d.f", nm, b),    32'(sf), 32'(eb));
                chk($sformatf("%s.b%0d.busy", nm, b), 32'(sb), 32'd1);
                chk($sformatf("%s.b%0d.rdy", nm, b),  32'(sr), 32'd0);
                chk($sformatf("%s.b%0d.done", nm, b), 32'(sd), 32'd0);
            end
        end
        @(negedge clk);
        chk({nm, ".done.done"}, 32'(sd), 32'd1);
        chk({nm, ".done.x"},    32'(sx), 32'd1);
        chk({nm, ".done.y"},    32'(sy), 32'd0);
        chk({nm, ".done.busy"}, 32'(sb), 32'd1);
        chk({nm, ".done.rdy"},  32'(sr), 32'd0);
    endtask

    task automatic drive(input logic [7:0] data, input logic valid);
        if (sel) begin d1 = data; v1 = valid; end
        else     begin d4 = data; v4 = valid; end
    endtask

    // Presents one word in IDLE and drops in_valid after the accept edge.
    task automatic start_frame(input logic [7:0] data, input string nm);
        wait_idle(nm);
        drive(data, 1'b1);
        @(posedge clk);
        #1 drive(8'h00, 1'b0);
    endtask

    vec_t vecs[8];
    int   cnt;

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b0, 1'b0};
        vecs[2] = '{8'h07, 1'b1, 1'b0};
        vecs[3] = '{8'h03, 1'b0, 1'b0};
        vecs[4] = '{8'h81, 1'b0, 1'b1};
        vecs[5] = '{8'h01, 1'b1, 1'b1};
        vecs[6] = '{8'h5A, 1'b0, 1'b1};
        vecs[7] = '{8'hFF, 1'b0, 1'b0};

        sel = 1'b0;
        rst = 1'b1;
        d4 = '0; v4 = 1'b0; d1 = '0; v1 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk_idle("rst4");
        sel = 1'b1;
        #0 chk_idle("rst1");
        sel = 1'b0;
        rst = 1'b0;

        // Table of single frames
        for (int i = 0; i < 8; i++) begin
            sel = vecs[i].sel;
            start_frame(vecs[i].data, $sformatf("v%0d", i));
            check_frame(vecs[i].data, vecs[i].par, sel ? 1 : 4, $sformatf("v%0d", i));
            @(negedge clk);
            chk_idle($sformatf("v%0d.after", i));
        end

        // Reset mid-frame: abort 0xA5 after 5 cycles
        sel = 1'b0;
        start_frame(8'hA5, "rstmid");
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_idle("rstmid.during");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_idle("rstmid.after");
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sx !== 1'b1 || sf !== 1'b0) cnt++;
        end
        chk("rstmid.no_bits", 32'(cnt), 32'd0);

        // Back-to-back: in_valid held high with 0xFF then 0x00
        sel = 1'b0;
        wait_idle("b2b");
        d4 = 8'hFF; v4 = 1'b1;
        @(posedge clk);
        #1 d4 = 8'h00;
        check_frame(8'hFF, 1'b0, 4, "b2b.f1");
        @(negedge clk);
        chk("b2b.gap2.x",   32'(sx), 32'd1);
        chk("b2b.gap2.rdy", 32'(sr), 32'd1);
        @(posedge clk);
        #1 v4 = 1'b0;
        check_frame(8'h00, 1'b0, 4, "b2b.f2");
        @(negedge clk);
        chk_idle("b2b.after");

        // Ignored input during SEND of 0x3C
        sel = 1'b0;
        start_frame(8'h3C, "ign");
        fork
            check_frame(8'h3C, 1'b0, 4, "ign");
            begin
                for (int i = 0; i < int'(NB) * 4; i++) begin
                    @(negedge clk);
                    #2;
                    d4 = 8'($urandom);
                    v4 = ((i % 3) == 0) && (i < int'(NB) * 4 - 2);
                end
                v4 = 1'b0;
            end
        join
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sd === 1'b1 || sx !== 1'b1) cnt++;
        end
        chk("ign.no_extra", 32'(cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
